// File: rtl/instruction_fetch_pkg.sv
// microarch_defs: shared fetch FSM states, latency bound and instruction layout
package microarch_defs;
  typedef enum logic [1:0] {FS_IDLE, FS_ADDR, FS_WAIT, FS_LOAD} fetch_state_t;
  localparam int MEM_LATENCY_MAX = 4;
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] operand;
  } instruction_t;
endpackage

// File: rtl/instruction_fetch_pc.sv
// program_counter: wrapping counter with parallel load (jump) taking priority over increment
module program_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else if (load) count_q <= load_val;
    else if (inc) count_q <= count_q + 1'b1;
  assign count = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: on request reads one program byte and strobes it into the instruction register
module instruction_fetch
  import microarch_defs::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic                  halt,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  ir_load,
  output logic                  fetch_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] pc
);
  localparam int LW = $clog2(MEM_LATENCY_MAX);
  fetch_state_t          state_q, state_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] ir_data_q, ir_data_d;
  logic                  ir_load_q;
  logic                  jump;
  program_counter #(.W(ADDR_WIDTH)) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (jump),
    .load_val (jump_addr),
    .inc      (state_q == FS_LOAD),
    .count    (pc)
  );
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    mem_addr_d = mem_addr_q;
    ir_data_d  = ir_data_q;
    jump       = 1'b0;
    case (state_q)
      FS_IDLE: begin
        // halt freezes the PC, so it also suppresses jumps
        jump = jump_en && !halt;
        if (!jump_en && fetch_req && !halt) begin
          state_d    = FS_ADDR;
          mem_addr_d = pc;
        end
      end
      FS_ADDR: begin
        lat_d   = LW'(MEM_LATENCY - 1);
        state_d = FS_WAIT;
      end
      FS_WAIT: begin
        lat_d     = (lat_q == '0) ? lat_q : lat_q - 1'b1;
        ir_data_d = (lat_q == '0) ? mem_data : ir_data_q;
        state_d   = (lat_q == '0) ? FS_LOAD : FS_WAIT;
      end
      FS_LOAD: state_d = FS_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= FS_IDLE;
      lat_q      <= '0;
      mem_addr_q <= '0;
      ir_data_q  <= '0;
      ir_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      mem_addr_q <= mem_addr_d;
      ir_data_q  <= ir_data_d;
      ir_load_q  <= state_d == FS_LOAD;
    end
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = (state_q == FS_ADDR) || (state_q == FS_WAIT);
  assign ir_data    = ir_data_q;
  assign ir_load    = ir_load_q;
  assign fetch_done = ir_load_q;
  assign busy       = state_q != FS_IDLE;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: two fetch units (MEM_LATENCY 1 and 3) against a PC/memory reference model
module tb_instruction_fetch;
  import microarch_defs::*;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       fetch_req [2];
  logic       halt      [2];
  logic       jump_en   [2];
  logic [3:0] jump_addr [2];
  logic [3:0] mem_addr  [2];
  logic [3:0] pc        [2];
  logic       mem_rd    [2];
  logic       ir_load   [2];
  logic       fetch_done[2];
  logic       busy      [2];
  logic [7:0] mem_data  [2];
  logic [7:0] ir_data   [2];
  logic [7:0] mem [16];
  int exp_pc [2];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] pipe [4];
    instruction_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req[g]), .halt(halt[g]),
      .jump_en(jump_en[g]), .jump_addr(jump_addr[g]), .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]),
      .mem_data(mem_data[g]), .ir_data(ir_data[g]), .ir_load(ir_load[g]),
      .fetch_done(fetch_done[g]), .busy(busy[g]), .pc(pc[g])
    );
    // memory returns the addressed byte MEM_LATENCY edges after a read; junk otherwise
    always @(posedge clk) begin
      pipe[0] <= mem_rd[g] ? mem[mem_addr[g]] : 8'($urandom);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_data[g] = pipe[g == 0 ? 0 : 2];
  end

  function automatic int lat(input int d);
    return d == 0 ? 1 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input int d);
    logic [7:0] exp_b;
    int k;
    exp_b = mem[exp_pc[d]];
    fetch_req[d] = 1'b1;
    step();
    fetch_req[d] = 1'b0;
    n_checks++;
    if (mem_addr[d] !== 4'(exp_pc[d]) || mem_rd[d] !== 1'b1 || busy[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_phase dut%0d: mem_addr=%h mem_rd=%b busy=%b, want %h/1/1", d, mem_addr[d], mem_rd[d], busy[d], 4'(exp_pc[d]));
    end
    k = 0;
    do begin step(); k++; end while (ir_load[d] !== 1'b1 && k < 20);
    n_checks++;
    if (k !== lat(d) + 1) begin
      n_fail++;
      $display("FAIL latency dut%0d: ir_load after %0d edges, want %0d", d, k, lat(d) + 1);
    end
    n_checks++;
    if (ir_data[d] !== exp_b || fetch_done[d] !== 1'b1 || mem_rd[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL load dut%0d: ir_data=%h fetch_done=%b mem_rd=%b, want %h/1/0", d, ir_data[d], fetch_done[d], mem_rd[d], exp_b);
    end
    step();
    exp_pc[d] = (exp_pc[d] + 1) % 16;
    n_checks++;
    if (pc[d] !== 4'(exp_pc[d]) || ir_load[d] !== 1'b0 || fetch_done[d] !== 1'b0 || busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_load dut%0d: pc=%h ir_load=%b fetch_done=%b busy=%b, want pc=%h 0/0/0", d, pc[d], ir_load[d], fetch_done[d], busy[d], 4'(exp_pc[d]));
    end
  endtask

  task automatic do_jump(input int d, input int a, input logic req);
    jump_en[d] = 1'b1;
    jump_addr[d] = 4'(a);
    fetch_req[d] = req;
    step();
    jump_en[d] = 1'b0;
    fetch_req[d] = 1'b0;
    exp_pc[d] = a;
    step();
    n_checks++;
    if (pc[d] !== 4'(a) || busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL jump dut%0d: pc=%h busy=%b, want %h/0", d, pc[d], busy[d], 4'(a));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fetch_req[d] = 1'b0; halt[d] = 1'b0; jump_en[d] = 1'b0; jump_addr[d] = '0; exp_pc[d] = 0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({pc[d], mem_addr[d], ir_data[d], mem_rd[d], ir_load[d], fetch_done[d], busy[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset dut%0d: pc=%h mem_addr=%h ir_data=%h rd=%b ld=%b done=%b busy=%b, want all 0", d, pc[d], mem_addr[d], ir_data[d], mem_rd[d], ir_load[d], fetch_done[d], busy[d]);
      end
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    instruction_t ins;
    mem[0] = 8'h1E;
    fetch_one(0);
    ins = ir_data[0];
    n_checks++;
    if (ins.opcode !== 4'h1 || ins.operand !== 4'hE) begin
      n_fail++;
      $display("FAIL fields: opcode=%h operand=%h, want 1/e", ins.opcode, ins.operand);
    end
  endtask

  task automatic test_back_to_back();
    int n, last, t;
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[3] = 8'h43;
    do_jump(0, 0, 1'b0);
    fetch_req[0] = 1'b1;
    n = 0; last = 0; t = 0;
    while (n < 4 && t < 80) begin
      step();
      t++;
      if (ir_load[0] === 1'b1) begin
        n_checks++;
        if (ir_data[0] !== mem[exp_pc[0]] || (n > 0 && t - last != 3 + lat(0))) begin
          n_fail++;
          $display("FAIL b2b load %0d: ir_data=%h spacing=%0d, want %h spacing %0d", n, ir_data[0], t - last, mem[exp_pc[0]], 3 + lat(0));
        end
        last = t;
        n++;
        exp_pc[0]++;
        if (n == 4) fetch_req[0] = 1'b0;
      end
    end
    step();
    step();
    n_checks++;
    if (n != 4 || pc[0] !== 4'h4 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b end: loads=%0d pc=%h busy=%b, want 4/4/0", n, pc[0], busy[0]);
    end
  endtask

  task automatic test_wrap();
    mem[15] = 8'hF0;
    do_jump(0, 15, 1'b0);
    fetch_one(0);
  endtask

  task automatic test_jump_priority();
    mem[9] = 8'h9C;
    do_jump(0, 9, 1'b1);
    fetch_one(0);
  endtask

  task automatic test_halt();
    logic [7:0] exp_b;
    int bad;
    exp_b = mem[exp_pc[0]];
    fetch_req[0] = 1'b1;
    step();
    fetch_req[0] = 1'b0;
    step();
    halt[0] = 1'b1;
    step();
    n_checks++;
    if (ir_load[0] !== 1'b1 || ir_data[0] !== exp_b) begin
      n_fail++;
      $display("FAIL halt_complete: ir_load=%b ir_data=%h, want 1/%h", ir_load[0], ir_data[0], exp_b);
    end
    exp_pc[0] = (exp_pc[0] + 1) % 16;
    fetch_req[0] = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (busy[0] !== 1'b0 || pc[0] !== 4'(exp_pc[0])) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_block: %0d cycles busy or pc moved, want 0 (pc=%h want %h)", bad, pc[0], 4'(exp_pc[0]));
    end
    fetch_req[0] = 1'b0;
    halt[0] = 1'b0;
    step();
    fetch_one(0);
  endtask

  task automatic test_reset_mid_fetch();
    int bad;
    mem[0] = 8'hA5;
    do_jump(1, 6, 1'b0);
    fetch_req[1] = 1'b1;
    step();
    fetch_req[1] = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pc[1] !== 4'h0 || busy[1] !== 1'b0 || mem_rd[1] !== 1'b0 || ir_load[1] !== 1'b0 || ir_data[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h busy=%b rd=%b ld=%b ir_data=%h, want 0", pc[1], busy[1], mem_rd[1], ir_load[1], ir_data[1]);
    end
    exp_pc[0] = 0;
    exp_pc[1] = 0;
    bad = 0;
    repeat (2) begin step(); if (ir_load[1] !== 1'b0 || fetch_done[1] !== 1'b0) bad++; end
    reset_n = 1'b1;
    repeat (6) begin step(); if (ir_load[1] !== 1'b0 || fetch_done[1] !== 1'b0 || busy[1] !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abandoned_fetch: %0d cycles with stray ir_load/fetch_done/busy, want 0", bad);
    end
    fetch_one(1);
    n_checks++;
    if (pc[0] !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_dut0_pc: pc=%h, want 0", pc[0]);
    end
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) do_jump(d, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else fetch_one(d);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_jump_priority();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
